// File: rtl/mips_pkg.sv
// Shared MIPS32 instruction-field definitions for the fetch/next-PC path.
package mips_pkg;

    // J-type opcodes
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

    // J-type field slices
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned TGT_MSB = 25;
    localparam int unsigned TGT_LSB = 0;

    // Opcode field of an instruction word
    function automatic logic [5:0] opcode_of(input logic [31:0] inst);
        return inst[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/jump_target_calc.sv
// Combinational J-type target formation and J/JAL opcode decode.
module jump_target_calc
    import mips_pkg::*;
(
    input  logic [3:0]  pc_hi,
    input  logic [31:0] inst,
    output logic [31:0] target,
    output logic        is_jump,
    output logic        is_link
);

    logic [5:0] opc;

    // Target is pure wiring: PC region bits, word index, word-aligned low bits
    always_comb begin
        opc     = opcode_of(inst);
        target  = {pc_hi, inst[TGT_MSB:TGT_LSB], 2'b00};
        is_jump = (opc == OP_J) || (opc == OP_JAL);
        is_link = (opc == OP_JAL);
    end

endmodule

// File: rtl/address_jump.sv
// MIPS32 jump-target generator: same-cycle target for the next-PC mux plus an
// optional registered copy with valid flag for pipelined consumers.
module address_jump
    import mips_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst,
    input  logic            in_valid,
    output logic [XLEN-1:0] o,
    output logic            is_jump,
    output logic            is_link,
    output logic [XLEN-1:0] o_q,
    output logic            o_valid,
    output logic            o_is_jump_q
);

    // Only the PC region bits contribute to the target
    logic unused_pc_lo;
    assign unused_pc_lo = ^pc[XLEN-5:0];

    jump_target_calc u_calc (
        .pc_hi   (pc[XLEN-1:XLEN-4]),
        .inst    (inst),
        .target  (o),
        .is_jump (is_jump),
        .is_link (is_link)
    );

    generate
        if (REG_OUT) begin : g_reg
            // Valid tracks every cycle; payload loads only on valid input and holds otherwise
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_q         <= '0;
                    o_valid     <= 1'b0;
                    o_is_jump_q <= 1'b0;
                end else begin
                    o_valid <= in_valid;
                    if (in_valid) begin
                        o_q         <= o;
                        o_is_jump_q <= is_jump;
                    end
                end
            end
        end else begin : g_noreg
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n ^ in_valid;
            assign o_q         = '0;
            assign o_valid     = 1'b0;
            assign o_is_jump_q = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_address_jump.sv
// Self-checking bench for address_jump: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_address_jump;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        in_valid;
    logic [31:0] o;
    logic        is_jump;
    logic        is_link;
    logic [31:0] o_q;
    logic        o_valid;
    logic        o_is_jump_q;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    address_jump #(.XLEN(32), .REG_OUT(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .inst        (inst),
        .in_valid    (in_valid),
        .o           (o),
        .is_jump     (is_jump),
        .is_link     (is_link),
        .o_q         (o_q),
        .o_valid     (o_valid),
        .o_is_jump_q (o_is_jump_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: arithmetic form of the target rule
    function automatic logic [31:0] m_target(input logic [31:0] p, input logic [31:0] i);
        return (p & 32'hF000_0000) | ((i & 32'h03FF_FFFF) * 4);
    endfunction

    function automatic logic m_is_jump(input logic [31:0] i);
        int unsigned op;
        op = i / 32'h0400_0000;
        return (op == 2) || (op == 3);
    endfunction

    function automatic logic m_is_link(input logic [31:0] i);
        return (i / 32'h0400_0000) == 3;
    endfunction

    logic [31:0] m_q;
    logic        m_valid;
    logic        m_isj_q;

    // Model of the registered stage
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     = 32'h0;
            m_valid = 1'b0;
            m_isj_q = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                m_q     = m_target(pc, inst);
                m_isj_q = m_is_jump(inst);
            end
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (started) begin
            chk32("model_o", o, m_target(pc, inst));
            chk1("model_is_jump", is_jump, m_is_jump(inst));
            chk1("model_is_link", is_link, m_is_link(inst));
            chk32("model_o_q", o_q, m_q);
            chk1("model_o_valid", o_valid, m_valid);
            chk1("model_o_is_jump_q", o_is_jump_q, m_isj_q);
        end
    end

    task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic v);
        @(posedge clk);
        #1;
        pc       = p;
        inst     = i;
        in_valid = v;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        pc       = 32'h0;
        inst     = 32'h0;
        in_valid = 1'b0;
        #12;
        chk32("reset_o_q", o_q, 32'h0);
        chk1("reset_o_valid", o_valid, 1'b0);
        chk1("reset_o_is_jump_q", o_is_jump_q, 1'b0);
        chk32("reset_comb_o_zero", o, 32'h0);
        #1;
        rst_n   = 1'b1;
        started = 1'b1;

        // Directed combinational vectors
        drive(32'hE000_0000, 32'h03FF_FFFF, 1'b0);
        chk32("vec1_o", o, 32'hEFFF_FFFC);
        chk1("vec1_is_jump", is_jump, 1'b0);

        drive(32'hA000_0000, 32'h030F_0FFF, 1'b0);
        chk32("vec2_o", o, 32'hAC3C_3FFC);
        chk1("vec2_is_jump", is_jump, 1'b0);

        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk32("allones_o", o, 32'hFFFF_FFFC);
        chk1("allones_is_jump", is_jump, 1'b0);

        drive(32'h0, 32'h0, 1'b0);
        chk32("zero_o", o, 32'h0);

        // J with valid, then registered copy one edge later
        drive(32'h4000_0010, 32'h0810_0004, 1'b1);
        chk32("j_o", o, 32'h4040_0010);
        chk1("j_is_jump", is_jump, 1'b1);
        chk1("j_is_link", is_link, 1'b0);
        chk1("j_o_valid_before_edge", o_valid, 1'b0);
        @(posedge clk);
        #1;
        chk32("j_o_q", o_q, 32'h4040_0010);
        chk1("j_o_valid", o_valid, 1'b1);
        chk1("j_o_is_jump_q", o_is_jump_q, 1'b1);

        // Drop valid: payload holds
        pc       = 32'h0;
        inst     = 32'h0C00_0001;
        in_valid = 1'b0;
        #1;
        chk32("jal_o", o, 32'h0000_0004);
        chk1("jal_is_jump", is_jump, 1'b1);
        chk1("jal_is_link", is_link, 1'b1);
        @(posedge clk);
        #1;
        chk32("hold_o_q", o_q, 32'h4040_0010);
        chk1("hold_o_valid", o_valid, 1'b0);
        chk1("hold_o_is_jump_q", o_is_jump_q, 1'b1);

        // Reset pulse between edges clears registered state immediately
        #1;
        rst_n = 1'b0;
        #1;
        chk32("rst_mid_o_q", o_q, 32'h0);
        chk1("rst_mid_o_valid", o_valid, 1'b0);
        chk1("rst_mid_o_is_jump_q", o_is_jump_q, 1'b0);
        pc   = 32'h3000_0000;
        inst = 32'h0800_0010;
        #1;
        chk32("rst_mid_comb_o", o, 32'h3000_0040);
        rst_n = 1'b1;

        // First load after release
        drive(32'h0, 32'h0C00_0001, 1'b1);
        @(posedge clk);
        #1;
        chk32("post_rst_o_q", o_q, 32'h0000_0004);
        chk1("post_rst_o_valid", o_valid, 1'b1);
        chk1("post_rst_o_is_jump_q", o_is_jump_q, 1'b1);

        // Non-jump load clears registered is_jump
        drive(32'h5000_0000, 32'h2000_0001, 1'b1);
        @(posedge clk);
        #1;
        chk32("nonjump_o_q", o_q, 32'h5000_0004);
        chk1("nonjump_o_is_jump_q", o_is_jump_q, 1'b0);

        // Back-to-back mixed traffic checked by the model
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ri;
            ri = $urandom;
            case (k % 4)
                0: ri[31:26] = 6'h02;
                1: ri[31:26] = 6'h03;
                default: ;
            endcase
            drive($urandom, ri, (($urandom % 3) != 0));
        end

        @(posedge clk);
        #6;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
